addsub_acc_sequencer: RTL and testbench

//  Command-driven accumulator stage that sits directly upstream of the 8-bit combinational adder/subtractor.
//  - Accepts ADD/SUB/LOAD/CLEAR commands over a valid/ready handshake.
//  - Drives registered operands a, b and mode into the adder, then captures its result and overflow.
//  - Keeps an accumulator, Z/N flags, a sticky V flag and a saturating operation counter.

---
 rtl/addsub_acc_sequencer_pkg.sv | 18 +
 rtl/addsub_acc_sequencer_if.sv | 15 +
 rtl/addsub_acc_sequencer.sv | 89 ++++++++
 tb/tb_addsub_acc_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_acc_sequencer_pkg.sv
// Shared command opcodes and sequencer state encoding for the accumulator stage
// that feeds the external 8-bit adder/subtractor.
package addsub_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD   = 2'b00;
  localparam op_t OP_SUB   = 2'b01;
  localparam op_t OP_LOAD  = 2'b10;
  localparam op_t OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/addsub_acc_sequencer_if.sv
// Command valid/ready channel into the accumulator sequencer.
interface addsub_acc_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  import addsub_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/addsub_acc_sequencer.sv
// Command-driven accumulator: registers operands into the external adder/subtractor,
// captures its result/overflow, and maintains Z/N, sticky V and a saturating op counter.
module addsub_acc_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_acc_sequencer_if.slave cmd,
  output logic [WIDTH-1:0]     as_a,
  output logic [WIDTH-1:0]     as_b,
  output logic                 as_mode,
  input  logic [WIDTH-1:0]     as_result,
  input  logic                 as_ovfl,
  output logic [WIDTH-1:0]     acc_out,
  output logic                 acc_valid,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_v,
  output logic [CNT_W-1:0]     op_count
);
  import addsub_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic             accept;

  assign accept  = cmd.cmd_valid && (state == ST_IDLE);
  assign acc_out = acc;
  assign as_a    = acc;
  // Z/N are pure functions of the registered accumulator, so they can never disagree with it.
  assign flag_z  = (acc == '0);
  assign flag_n  = acc[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd.cmd_ready = 1'b0;
    acc_valid     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid)
          state_nxt = (cmd.cmd_op[1] == 1'b0) ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: begin
        acc_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      as_b     <= '0;
      as_mode  <= 1'b0;
      flag_v   <= 1'b0;
      op_count <= '0;
    end else if (accept) begin
      unique case (cmd.cmd_op)
        OP_ADD, OP_SUB: begin
          as_b    <= cmd.cmd_data;
          as_mode <= cmd.cmd_op[0];
        end
        OP_LOAD: acc <= cmd.cmd_data;
        OP_CLEAR: begin
          acc      <= '0;
          flag_v   <= 1'b0;
          op_count <= '0;
        end
        default: ;
      endcase
    end else if (state == ST_EXEC) begin
      acc    <= as_result;
      flag_v <= flag_v | as_ovfl;
      if (op_count != '1) op_count <= op_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_addsub_acc_sequencer.sv
// Directed bench: two sequencers (CNT_W=8 and CNT_W=2) share one command stream, each
// driving its own adder/subtractor stand-in, checked every cycle against a transaction model.
module tb_addsub_acc_sequencer;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  addsub_acc_sequencer_if #(.WIDTH(8)) cif  ();
  addsub_acc_sequencer_if #(.WIDTH(8)) cif2 ();

  logic [7:0] as_a,  as_b,  res,  acc_out;
  logic [7:0] as_a2, as_b2, res2, acc_out2;
  logic       as_mode, ovf, acc_valid, flag_z, flag_n, flag_v;
  logic       as_mode2, ovf2, acc_valid2, flag_z2, flag_n2, flag_v2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  // Behavioural adder/subtractor: 8-bit wrap, two's-complement overflow.
  function automatic logic [8:0] addsub(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [7:0] r;
    logic       v;
    r = m ? (a - b) : (a + b);
    v = (a[7] == (b[7] ^ m)) && (r[7] != a[7]);
    return {v, r};
  endfunction

  assign {ovf,  res}  = addsub(as_a,  as_b,  as_mode);
  assign {ovf2, res2} = addsub(as_a2, as_b2, as_mode2);

  addsub_acc_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif.slave),
    .as_a(as_a), .as_b(as_b), .as_mode(as_mode), .as_result(res), .as_ovfl(ovf),
    .acc_out(acc_out), .acc_valid(acc_valid), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .op_count(op_count)
  );

  addsub_acc_sequencer #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd(cif2.slave),
    .as_a(as_a2), .as_b(as_b2), .as_mode(as_mode2), .as_result(res2), .as_ovfl(ovf2),
    .acc_out(acc_out2), .acc_valid(acc_valid2), .flag_z(flag_z2), .flag_n(flag_n2),
    .flag_v(flag_v2), .op_count(op_count2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: result computed with signed integers at accept time,
  // made visible after the adder latency; m_busy counts edges until the next accept.
  int m_acc = 0, m_b = 0, m_cnt8 = 0, m_cnt2 = 0, m_busy = 0, p_res = 0;
  bit m_v = 0, m_mode = 0, m_valid = 0, m_pend = 0, p_ovf = 0;

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int s;
    if (!rst_n) begin
      m_acc = 0; m_b = 0; m_mode = 0; m_v = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_busy = 0; m_pend = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_pend) begin
          m_acc = p_res;
          m_v = m_v | p_ovf;
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
          m_pend = 0;
          m_valid = 1;
        end
      end else if (cif.cmd_valid) begin
        case (cif.cmd_op)
          OP_ADD, OP_SUB: begin
            m_b = int'(cif.cmd_data);
            m_mode = cif.cmd_op[0];
            s = m_mode ? sx(m_acc) - sx(m_b) : sx(m_acc) + sx(m_b);
            p_res = s & 255;
            p_ovf = (s < -128) || (s > 127);
            m_pend = 1;
            m_busy = 2;
          end
          OP_LOAD: begin
            m_acc = int'(cif.cmd_data);
            m_valid = 1;
            m_busy = 1;
          end
          default: begin
            m_acc = 0; m_v = 0; m_cnt8 = 0; m_cnt2 = 0;
            m_valid = 1;
            m_busy = 1;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("acc_out",   int'(acc_out),   m_acc);
    chk("as_a",      int'(as_a),      m_acc);
    chk("as_b",      int'(as_b),      m_b);
    chk("as_mode",   int'(as_mode),   int'(m_mode));
    chk("flag_z",    int'(flag_z),    int'(m_acc == 0));
    chk("flag_n",    int'(flag_n),    int'(m_acc >= 128));
    chk("flag_v",    int'(flag_v),    int'(m_v));
    chk("acc_valid", int'(acc_valid), int'(m_valid));
    chk("cmd_ready", int'(cif.cmd_ready), int'(m_busy == 0));
    chk("op_count",  int'(op_count),  m_cnt8);
    chk("acc_out2",  int'(acc_out2),  m_acc);
    chk("op_count2", int'(op_count2), m_cnt2);
    chk("cmd_ready2", int'(cif2.cmd_ready), int'(m_busy == 0));
  end

  task automatic drive(input logic v, input op_t op, input logic [7:0] d);
    cif.cmd_valid  = v; cif.cmd_op  = op; cif.cmd_data  = d;
    cif2.cmd_valid = v; cif2.cmd_op = op; cif2.cmd_data = d;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cif.cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cif.cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready stuck 0 at %0t", $time);
    end
  endtask

  // Returns 1ns after the accepting edge.
  task automatic send(input op_t op, input logic [7:0] d);
    drive(1'b1, op, d);
    wait_ready();
    @(posedge clk); #1;
    drive(1'b0, op, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers;
    drive(1'b0, OP_ADD, 8'h00);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst acc", int'(acc_out), 0);
    chk("rst z", int'(flag_z), 1);
    chk("rst cnt", int'(op_count), 0);

    // 1: signed overflow into 0x80
    send(OP_LOAD, 8'h7F); wait_ready();
    send(OP_ADD, 8'h01);
    chk("t1 valid T", int'(acc_valid), 0);
    @(posedge clk); #1;
    chk("t1 valid T+1", int'(acc_valid), 1);
    chk("t1 acc", int'(acc_out), 8'h80);
    @(posedge clk); #1;
    chk("t1 valid T+2", int'(acc_valid), 0);
    chk("t1 n", int'(flag_n), 1);
    chk("t1 z", int'(flag_z), 0);
    chk("t1 v", int'(flag_v), 1);
    chk("t1 cnt", int'(op_count), 1);

    // 2: SUB overflow, then V sticky
    send(OP_CLEAR, 8'h00); wait_ready();
    chk("t2 clr v", int'(flag_v), 0);
    send(OP_LOAD, 8'h80); wait_ready();
    send(OP_SUB, 8'h01); wait_ready();
    chk("t2 acc", int'(acc_out), 8'h7F);
    chk("t2 v", int'(flag_v), 1);
    send(OP_ADD, 8'h01); wait_ready();
    chk("t2 acc2", int'(acc_out), 8'h80);
    chk("t2 v sticky", int'(flag_v), 1);

    // 3: unsigned wrap is not overflow
    send(OP_CLEAR, 8'h00); wait_ready();
    send(OP_LOAD, 8'hFF); wait_ready();
    send(OP_ADD, 8'h01); wait_ready();
    chk("t3 acc", int'(acc_out), 0);
    chk("t3 z", int'(flag_z), 1);
    chk("t3 v", int'(flag_v), 0);

    // 4: back-to-back ADD 3 with valid held
    send(OP_CLEAR, 8'h00); wait_ready();
    drive(1'b1, OP_ADD, 8'h03);
    xfers = 0;
    for (int i = 0; i < 15 && xfers < 4; i++) begin
      chk("t4 ready pattern", int'(cif.cmd_ready), int'(i % 3 == 0));
      if (cif.cmd_ready) xfers++;
      @(posedge clk); #1;
    end
    drive(1'b0, OP_ADD, 8'h03);
    chk("t4 xfers", xfers, 4);
    wait_ready();
    chk("t4 acc", int'(acc_out), 8'h0C);
    chk("t4 cnt", int'(op_count), 4);
    chk("t4 cnt sat", int'(op_count2), 3);

    // 6: saturation on the CNT_W=2 instance
    send(OP_CLEAR, 8'h00); wait_ready();
    for (int i = 0; i < 4; i++) begin
      send(OP_ADD, 8'h01); wait_ready();
      chk("t6 cnt2", int'(op_count2), (i < 3) ? i + 1 : 3);
    end
    chk("t6 cnt8", int'(op_count), 4);
    send(OP_CLEAR, 8'h00); wait_ready();
    chk("t6 clr cnt2", int'(op_count2), 0);

    // 5: async reset mid-EXEC
    send(OP_LOAD, 8'h20); wait_ready();
    send(OP_SUB, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 acc", int'(acc_out), 0);
    chk("t5 z", int'(flag_z), 1);
    chk("t5 valid", int'(acc_valid), 0);
    chk("t5 as_b", int'(as_b), 0);
    chk("t5 mode", int'(as_mode), 0);
    chk("t5 ready", int'(cif.cmd_ready), 1);
    @(posedge clk); #1;
    chk("t5 no pulse", int'(acc_valid), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5 acc after", int'(acc_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
